// File: rtl/normalizer_pkg.sv
// Shared definitions for the sequential normalizer: FSM state encoding.
package normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

endpackage

// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts an operand one bit per cycle toward MSB or LSB
// until the target bit is set, reporting the shift count and an all-zero flag.
module seq_normalizer
  import normalizer_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  data_in,
  input  logic          direction,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  data_out,
  output logic [SW-1:0] shift_amount,
  output logic          zero
);

  norm_state_e   state_reg, state_next;
  logic [N-1:0]  work_reg, work_next;
  logic          dir_reg, dir_next;
  logic [SW-1:0] count_reg, count_next;
  logic [N-1:0]  data_out_reg, data_out_next;
  logic [SW-1:0] shift_reg, shift_next;
  logic          zero_reg, zero_next;
  logic          in_ready_reg, out_valid_reg;
  logic          target_bit;

  assign target_bit = dir_reg ? work_reg[0] : work_reg[N-1];

  always_comb begin
    state_next    = state_reg;
    work_next     = work_reg;
    dir_next      = dir_reg;
    count_next    = count_reg;
    data_out_next = data_out_reg;
    shift_next    = shift_reg;
    zero_next     = zero_reg;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next  = data_in;
          dir_next   = direction;
          count_next = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (work_reg == '0) begin
          data_out_next = '0;
          shift_next    = '0;
          zero_next     = 1'b1;
          state_next    = DONE;
        end else if (target_bit) begin
          data_out_next = work_reg;
          shift_next    = count_reg;
          zero_next     = 1'b0;
          state_next    = DONE;
        end else begin
          // A nonzero operand reaches its target bit within N-1 shifts,
          // so the counter cannot overflow here.
          work_next  = dir_reg ? {1'b0, work_reg[N-1:1]} : {work_reg[N-2:0], 1'b0};
          count_next = count_reg + SW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      dir_reg       <= 1'b0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      shift_reg     <= '0;
      zero_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      work_reg      <= work_next;
      dir_reg       <= dir_next;
      count_reg     <= count_next;
      data_out_reg  <= data_out_next;
      shift_reg     <= shift_next;
      zero_reg      <= zero_next;
      // Handshake flags registered alongside the state so outputs come straight from flops
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_next == DONE);
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign data_out     = data_out_reg;
  assign shift_amount = shift_reg;
  assign zero         = zero_reg;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed self-checking bench for seq_normalizer (N = 8).
module tb_seq_normalizer;

  localparam int N  = 8;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  data_in;
  logic          direction;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  data_out;
  logic [SW-1:0] shift_amount;
  logic          zero;

  int checks   = 0;
  int failures = 0;

  seq_normalizer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .direction    (direction),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .shift_amount (shift_amount),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand, measure edges to out_valid, check results, then drain.
  task automatic run(input logic [7:0] din, input logic dir, input logic [7:0] exp_out,
                     input int exp_sh, input logic exp_zero, input int exp_lat);
    int lat;
    string t;
    t = $sformatf("%02h/d%0d", din, dir);
    chk({t, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    data_in   = din;
    direction = dir;
    step();
    in_valid  = 1'b0;
    data_in   = 8'hA5;
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (out_valid) break;
    end
    chk({t, " latency"}, 32'(lat), 32'(exp_lat));
    chk({t, " data_out"}, 32'(data_out), 32'(exp_out));
    chk({t, " shift_amount"}, 32'(shift_amount), 32'(exp_sh));
    chk({t, " zero"}, 32'(zero), 32'(exp_zero));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({t, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({t, " data_out hold"}, 32'(data_out), 32'(exp_out));
    $display("txn din=%02h dir=%0d -> out=%02h sh=%0d zero=%0d lat=%0d",
             din, dir, data_out, shift_amount, zero, lat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0; direction = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    chk("reset shift_amount", 32'(shift_amount), 32'd0);
    chk("reset zero", 32'(zero), 32'd0);

    run(8'h10, 1'b0, 8'h80, 3, 1'b0, 4);
    run(8'h10, 1'b1, 8'h01, 4, 1'b0, 5);
    run(8'h01, 1'b0, 8'h80, 7, 1'b0, 8);
    run(8'h80, 1'b0, 8'h80, 0, 1'b0, 1);
    run(8'h00, 1'b0, 8'h00, 0, 1'b1, 1);
    run(8'h80, 1'b1, 8'h01, 7, 1'b0, 8);
    run(8'h06, 1'b1, 8'h03, 1, 1'b0, 2);
    run(8'h06, 1'b0, 8'hC0, 5, 1'b0, 6);
    run(8'h00, 1'b1, 8'h00, 0, 1'b1, 1);

    // Back-pressure: result held in DONE while a new operand is offered
    in_valid = 1'b1; data_in = 8'h10; direction = 1'b0;
    step();
    data_in = 8'hFF; direction = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("hold reach out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      chk("hold data_out", 32'(data_out), 32'h80);
      chk("hold shift_amount", 32'(shift_amount), 32'd3);
      chk("hold zero", 32'(zero), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold release out_valid", 32'(out_valid), 32'd0);
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    $display("txn hold din=10 dir=0 -> out=%02h sh=%0d released", data_out, shift_amount);

    // Reset mid-SHIFT
    in_valid = 1'b1; data_in = 8'h01; direction = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("midshift in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst data_out", 32'(data_out), 32'd0);
    chk("midrst shift_amount", 32'(shift_amount), 32'd0);
    chk("midrst zero", 32'(zero), 32'd0);
    $display("txn reset mid-shift din=01 -> in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run(8'h40, 1'b0, 8'h80, 1, 1'b0, 2);

    // Reset wins over an accept on the same edge
    rst = 1'b1; in_valid = 1'b1; data_in = 8'h01; direction = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("rst priority in_ready", 32'(in_ready), 32'd1);
    chk("rst priority out_valid", 32'(out_valid), 32'd0);
    $display("txn reset-vs-accept -> in_ready=%0d", in_ready);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 Parameter N, default 8: data width; SHALL be a power of two, N >= 2.
REQ-002 Parameter SW, default $clog2(N): width of shift_amount; SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  data_in and direction are valid.
REQ-006 in_ready  output  1  block can accept a new operand.
REQ-007 data_in  input  N  operand to normalize.
REQ-008 direction  input  1  0 = normalize toward MSB (left), 1 = normalize toward LSB (right).
REQ-009 out_valid  output  1  result fields valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 data_out  output  N  normalized operand.
REQ-012 shift_amount  output  SW  number of 1-bit shifts applied; feeding data_out back through a shift of this amount in the opposite direction restores data_in.
REQ-013 zero  output  1  data_in was all zeros.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept occurs on an edge where in_ready && in_valid.
REQ-016 On accept: working register <- data_in, direction latched, count <- 0, state -> SHIFT.
REQ-017 Target bit: bit N-1 when latched direction = 0, bit 0 when it = 1.
REQ-018 In SHIFT, if the working register is all zeros: state -> DONE, zero <- 1, data_out = 0, shift_amount = 0.
REQ-019 In SHIFT, if the target bit is 1: state -> DONE, zero <- 0.
REQ-020 Otherwise in SHIFT: working register shifts 1 bit toward the target end, zero-filled, and count increments by 1.
REQ-021 For nonzero input requiring k shifts (0 <= k <= N-1), out_valid SHALL rise exactly k+1 edges after the accept edge; all-zero input takes 1 edge.
REQ-022 count SHALL never exceed N-1 and SHALL never wrap.
REQ-023 In DONE: out_valid = 1; data_out, shift_amount and zero SHALL remain stable until the handshake.
REQ-024 On an edge with out_valid && out_ready: state -> IDLE; the next accept occurs no earlier than the following edge.
REQ-025 Outside DONE: out_valid = 0; data_out, shift_amount and zero hold their last values.
REQ-026 in_valid, data_in and direction SHALL be ignored outside IDLE.

Reset
REQ-027 rst = 1 at an edge SHALL force, from any state including mid-SHIFT: state IDLE, in_ready 1, out_valid 0, data_out 0, shift_amount 0, zero 0, count 0.
REQ-028 rst SHALL take priority over all handshakes on the same edge.

Structure
REQ-029 The state encoding (IDLE/SHIFT/DONE) typedef SHALL reside in the shared package normalizer_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the 1-bit shift is inline.
REQ-031 Outputs SHALL be driven directly from registers; there SHALL be no combinational path from data_in to data_out.

Verification (N = 8)
REQ-032 data_in 0x10, direction 0 -> data_out 0x80, shift_amount 3, zero 0, out_valid 4 edges after accept.
REQ-033 data_in 0x10, direction 1 -> data_out 0x01, shift_amount 4, out_valid 5 edges after accept.
REQ-034 data_in 0x01, direction 0 -> data_out 0x80, shift_amount 7 (max, no wrap); data_in 0x80, direction 0 -> shift_amount 0, out_valid after 1 edge.
REQ-035 data_in 0x00 -> zero 1, data_out 0x00, shift_amount 0, out_valid after 1 edge.
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0, and a new in_valid is ignored; out_ready 1 -> IDLE on the next edge.
REQ-037 rst pulsed 2 edges after accepting 0x01 -> all outputs at reset values; a following 0x40 with direction 0 yields shift_amount 1.
